mod_exp_engine: RTL and testbench

MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

---
 rtl/mod_exp_if.sv | 33 +++
 rtl/mod_exp_engine.sv | 136 +++++++++++++
 tb/tb_mod_exp_engine.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mod_exp_if.sv
// mod_exp_if -- request/response bundle for the modular exponentiation engine.
//   start    : request strobe, sampled only while the engine is idle
//   base     : operand (message or ciphertext), WIDTH bits
//   exponent : exponent, EXP_WIDTH bits
//   modulus  : modulus n, WIDTH bits
//   busy     : engine occupied, from the cycle after acceptance through DONE
//   done     : one-cycle completion pulse
//   result   : base^exponent mod modulus, held until the next accepted job
//   error    : operand fault flag (modulus < 2 or base >= modulus)
// The master modport belongs to the requester; the slave modport to the engine.
interface mod_exp_if #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     base;
  logic [EXP_WIDTH-1:0] exponent;
  logic [WIDTH-1:0]     modulus;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;
  logic                 error;

  modport master (
    output start, base, exponent, modulus,
    input  busy, done, result, error
  );

  modport slave (
    input  start, base, exponent, modulus,
    output busy, done, result, error
  );
endinterface

// File: rtl/mod_exp_engine.sv
// mod_exp_engine -- iterative modular exponentiation, base^exponent mod modulus.
// Right-to-left square-and-multiply. Each exponent bit costs WIDTH MULT cycles,
// in which r*b mod n and b*b mod n are built in parallel by MSB-first
// add-shift-reduce, plus one NEXT cycle that commits them.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears all state
//   bus   : mod_exp_if.slave (start/base/exponent/modulus in;
//           busy/done/result/error out)
module mod_exp_engine #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  mod_exp_if.slave  bus
);
  // Accumulators carry two extra bits: 2*acc + multiplicand < 3n before reduction.
  localparam int AW = WIDTH + 2;
  // Remaining-bit counter must hold EXP_WIDTH itself (all-ones exponent).
  localparam int CW = $clog2(EXP_WIDTH + 1);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, MULT, NEXT, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     r_q, b_q, n_q, result_q;
  logic [EXP_WIDTH-1:0] e_q, e_shr;
  logic [CW-1:0]        cnt_q, k;
  logic [BW-1:0]        bit_q;
  logic [AW-1:0]        acc_r_q, acc_b_q, acc_r_nxt, acc_b_nxt;
  logic                 error_q, op_fault, mul_bit, busy_c, done_c;

  // One interleaved step: shift, conditionally add, then at most two
  // subtractions of n bring the accumulator back below n.
  function automatic logic [AW-1:0] mod_step(input logic [AW-1:0]    acc,
                                              input logic             add_en,
                                              input logic [WIDTH-1:0] mcand,
                                              input logic [WIDTH-1:0] n);
    logic [AW-1:0] t, nn;
    nn = {2'b00, n};
    t  = {acc[AW-2:0], 1'b0} + (add_en ? {2'b00, mcand} : '0);
    if (t >= nn) t = t - nn;
    if (t >= nn) t = t - nn;
    return t;
  endfunction

  assign op_fault  = (n_q < WIDTH'(2)) || (b_q >= n_q);
  assign e_shr     = e_q >> 1;
  // b supplies the multiplier bit for both products (r*b and b*b).
  assign mul_bit   = b_q[bit_q];
  assign acc_r_nxt = mod_step(acc_r_q, mul_bit, r_q, n_q);
  assign acc_b_nxt = mod_step(acc_b_q, mul_bit, b_q, n_q);

  // Number of significant exponent bits.
  always_comb begin
    k = '0;
    for (int i = 0; i < EXP_WIDTH; i++) begin
      if (e_q[i]) k = CW'(i + 1);
    end
  end

  always_comb begin
    state_nxt = state;
    busy_c    = (state != IDLE);
    done_c    = (state == DONE);
    unique case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = (op_fault || (e_q == '0)) ? DONE : MULT;
      MULT:    if (bit_q == '0) state_nxt = NEXT;
      NEXT:    state_nxt = (e_shr == '0) ? DONE : MULT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      e_q      <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      acc_r_q  <= '0;
      acc_b_q  <= '0;
      result_q <= '0;
      error_q  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            b_q      <= bus.base;
            e_q      <= bus.exponent;
            n_q      <= bus.modulus;
            result_q <= '0;
            error_q  <= '0;
          end
        end
        LOAD: begin
          r_q     <= WIDTH'(1);
          cnt_q   <= k;
          bit_q   <= BW'(WIDTH - 1);
          acc_r_q <= '0;
          acc_b_q <= '0;
          if (op_fault)        error_q  <= 1'b1;
          else if (e_q == '0)  result_q <= WIDTH'(1);
        end
        MULT: begin
          acc_r_q <= acc_r_nxt;
          acc_b_q <= acc_b_nxt;
          bit_q   <= bit_q - 1'b1;
        end
        NEXT: begin
          if (e_q[0]) r_q <= acc_r_q[WIDTH-1:0];
          b_q     <= acc_b_q[WIDTH-1:0];
          e_q     <= e_shr;
          cnt_q   <= cnt_q - 1'b1;
          bit_q   <= BW'(WIDTH - 1);
          acc_r_q <= '0;
          acc_b_q <= '0;
          // Last iteration: publish the product directly so it is valid in DONE.
          if (e_shr == '0) result_q <= e_q[0] ? acc_r_q[WIDTH-1:0] : r_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;
  assign bus.error  = error_q;
endmodule

// File: tb/tb_mod_exp_engine.sv
// tb_mod_exp_engine -- self-checking bench for mod_exp_engine (WIDTH=16, EXP_WIDTH=16).
// A timeline model predicts busy/done/result/error each cycle from the job
// operands; directed jobs additionally check literal results and done cycles.
module tb_mod_exp_engine;
  localparam int W  = 16;
  localparam int EW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod_exp_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus ();

  mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint model_modexp(longint b, longint e, longint m);
    longint r = 1;
    b = b % m;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * b) % m;
      b = (b * b) % m;
      e = e / 2;
    end
    return r;
  endfunction

  function automatic bit model_error(int b, int e, int m);
    return (m < 2) || (b >= m);
  endfunction

  function automatic int model_result(int b, int e, int m);
    if (model_error(b, e, m)) return 0;
    if (e == 0) return 1;
    return int'(model_modexp(b, e, m));
  endfunction

  function automatic int model_cycles(int b, int e, int m);
    int nbits = 0;
    if (model_error(b, e, m) || e == 0) return 2;
    for (int i = 0; i < EW; i++) if ((e >> i) & 1) nbits = i + 1;
    return 2 + nbits * (W + 1);
  endfunction

  // Timeline: m_cyc is the cycle index within the active job (acceptance = 0).
  bit m_active = 0;
  int m_cyc = 0, m_d = 0, f_res = 0, m_res = 0;
  bit f_err = 0, m_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_cyc = 0; m_res = 0; m_err = 0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active = 1;
        m_cyc    = 1;
        m_d      = model_cycles(int'(bus.base), int'(bus.exponent), int'(bus.modulus));
        f_res    = model_result(int'(bus.base), int'(bus.exponent), int'(bus.modulus));
        f_err    = model_error(int'(bus.base), int'(bus.exponent), int'(bus.modulus));
        m_res    = 0;
        m_err    = 0;
      end
    end else begin
      m_cyc++;
      if (m_cyc == m_d) begin
        m_res = f_res;
        m_err = f_err;
      end else if (m_cyc == m_d + 1) begin
        m_active = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("busy",   bus.busy,   m_active);
    check("done",   bus.done,   m_active && (m_cyc == m_d));
    check("result", bus.result, m_res);
    check("error",  bus.error,  m_err);
  end

  // ---------------- directed helpers ----------------
  task automatic wait_done(input int t0, input int want_cyc, input int want_res,
                           input bit want_err, input string name);
    bit found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done) begin found = 1; break; end
    end
    if (!found) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      check({name, "_cycle"},  cyc_cnt - t0, want_cyc);
      check({name, "_result"}, bus.result,   want_res);
      check({name, "_error"},  bus.error,    want_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int b, input int e, input int m, input int want_cyc,
                         input int want_res, input bit want_err, input string name);
    int t0;
    bus.start = 1'b1;
    bus.base = W'(b); bus.exponent = EW'(e); bus.modulus = W'(m);
    t0 = cyc_cnt;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(t0, want_cyc, want_res, want_err, name);
  endtask

  initial begin
    int t0, t1, b, e, m;
    bus.start = 1'b0; bus.base = '0; bus.exponent = '0; bus.modulus = '0;

    // Pin the model on hand-computed values.
    check("model_enc", model_modexp(65, 17, 3233), 2790);
    check("model_dec", model_modexp(2790, 2753, 3233), 65);
    check("model_pow", model_modexp(2, 10, 3233), 1024);
    check("model_cyc", model_cycles(2790, 2753, 3233), 206);

    repeat (3) @(posedge clk); #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_error", bus.error, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(65, 17, 3233, 87, 2790, 0, "enc");
    run_job(2790, 2753, 3233, 206, 65, 0, "dec");
    run_job(5, 0, 7, 2, 1, 0, "exp0");
    run_job(5, 17, 1, 2, 0, 1, "mod1");
    run_job(3233, 17, 3233, 2, 0, 1, "base_eq_mod");
    run_job(0, 0, 1, 2, 0, 1, "mod1_exp0");
    run_job(3, 16'hFFFF, 65521, 274, model_result(3, 65535, 65521), 0, "exp_ones");

    // start held high through a job, operands changed mid-job.
    bus.start = 1'b1; bus.base = 16'd65; bus.exponent = 16'd17; bus.modulus = 16'd3233;
    t0 = cyc_cnt;
    @(posedge clk); #1;
    repeat (10) @(posedge clk); #1;
    bus.base = 16'd2; bus.exponent = 16'd10;
    wait_done(t0, 87, 2790, 0, "hold_first");
    t1 = cyc_cnt;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(t1, 70, 1024, 0, "hold_second");

    // Reset in cycle 40 of an encrypt job.
    bus.start = 1'b1; bus.base = 16'd65; bus.exponent = 16'd17; bus.modulus = 16'd3233;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (39) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_error", bus.error, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(65, 17, 3233, 87, 2790, 0, "rerun");

    // Sweep, back-to-back.
    for (int i = 0; i < 256; i++)
      run_job(i, 17, 3233, 87, model_result(i, 17, 3233), 0, "sweep");

    // Randomized jobs, with occasional faults and extreme exponents.
    for (int j = 0; j < 24; j++) begin
      m = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0 || m == 0) b = int'($urandom_range(0, 65535));
      else b = int'($urandom_range(0, m - 1));
      case ($urandom_range(0, 5))
        0:       e = 0;
        1:       e = 65535;
        default: e = int'($urandom_range(1, 65535));
      endcase
      run_job(b, e, m, model_cycles(b, e, m), model_result(b, e, m),
              model_error(b, e, m), "rand");
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
